tgen_initiator: RTL and testbench

Synthesizable bus-master traffic generator for the master (CH0) side of `XBAR_L2`. On a start pulse it writes a block of words at consecutive interleaved addresses, reads the same block back, and compares every read word against the expected pattern. It reports pass/fail, an error count and the first failing address, and replaces bench-driven stimulus so that the crossbar-plus-BRAM path can be exercised on hardware. One instance drives one master port; N_CH0 instances cover all ports.

---
 rtl/tgen_pkg.sv | 28 ++
 rtl/tgen_resp_checker.sv | 33 +++
 rtl/tgen_initiator.sv | 151 +++++++++++++++
 tb/tb_tgen_initiator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tgen_pkg.sv
// Shared types, default widths and the data pattern for the tgen traffic generator.
package tgen_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_RSP = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_RSP = 3'd4,
    S_DONE   = 3'd5
  } tgen_state_e;

  // Seed XOR as many whole copies of the address as fit, upper leftover bits zero.
  function automatic logic [DATA_W_DEF-1:0] tgen_pattern(input logic [DATA_W_DEF-1:0] seed,
                                                         input logic [ADDR_W_DEF-1:0] addr);
    logic [DATA_W_DEF-1:0] rep;
    rep = '0;
    for (int b = 0; b + ADDR_W_DEF <= DATA_W_DEF; b += ADDR_W_DEF) begin
      rep[b +: ADDR_W_DEF] = addr;
    end
    return seed ^ rep;
  endfunction

endpackage

// File: rtl/tgen_resp_checker.sv
// Read-response compare with saturating error count and first-mismatch address capture.
module tgen_resp_checker
  import tgen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [DATA_W-1:0] i_act,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  logic w_mismatch;
  assign w_mismatch = i_valid && (i_exp != i_act);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      o_err_cnt        <= '0;
      o_first_err_addr <= '0;
    end else if (w_mismatch) begin
      if (o_err_cnt == '0) o_first_err_addr <= i_addr;
      if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tgen_initiator.sv
// Write-then-readback bus-master traffic generator for one XBAR_L2 master port.
// Optional response watchdog and timeout_o port: define TGEN_TIMEOUT_EN.
module tgen_initiator
  import tgen_pkg::*;
#(
  parameter int ADDR_IN_WIDTH  = ADDR_W_DEF,
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int LEN_WIDTH      = LEN_W_DEF,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [ADDR_IN_WIDTH-1:0] cfg_base_i,
  input  logic [LEN_WIDTH-1:0]     cfg_len_i,
  input  logic [DATA_WIDTH-1:0]    cfg_seed_i,
  output logic                     data_req_o,
  output logic [ADDR_IN_WIDTH-1:0] data_add_o,
  output logic                     data_wen_o,
  output logic [DATA_WIDTH-1:0]    data_wdata_o,
  output logic [BE_WIDTH-1:0]      data_be_o,
  input  logic                     data_gnt_i,
  input  logic                     data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]    data_r_rdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [LEN_WIDTH-1:0]     err_cnt_o,
  output logic [ADDR_IN_WIDTH-1:0] first_err_addr_o,
`ifdef TGEN_TIMEOUT_EN
  output logic                     timeout_o,
`endif
  output logic [2:0]               dbg_state_o
);

  tgen_state_e r_state, w_next;
  logic [LEN_WIDTH-1:0]     r_idx, r_len;
  logic [ADDR_IN_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0]    r_seed;
  logic                     r_pass;
  logic [ADDR_IN_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]    w_pattern;
  logic w_start_ok, w_last, w_req, w_wd_hit, w_timeout, w_pass_now, w_rsp_ok;

  assign w_start_ok = (r_state == S_IDLE) && start_i;
  assign w_addr     = r_base + ADDR_IN_WIDTH'(r_idx);
  assign w_pattern  = tgen_pattern(r_seed, w_addr);
  assign w_last     = (r_idx == r_len - LEN_WIDTH'(1));
  assign w_req      = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
  assign w_rsp_ok   = ((r_state == S_WR_RSP) || (r_state == S_RD_RSP)) && data_r_valid_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_next = (cfg_len_i == '0) ? S_DONE : S_WR_REQ;
      S_WR_REQ: if (data_gnt_i) w_next = S_WR_RSP;
      S_WR_RSP: begin
        if (data_r_valid_i) w_next = w_last ? S_RD_REQ : S_WR_REQ;
        else if (w_wd_hit)  w_next = S_DONE;
      end
      S_RD_REQ: if (data_gnt_i) w_next = S_RD_RSP;
      S_RD_RSP: begin
        if (data_r_valid_i) w_next = w_last ? S_DONE : S_RD_REQ;
        else if (w_wd_hit)  w_next = S_DONE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_base  <= '0;
      r_seed  <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_base <= cfg_base_i;
        r_len  <= cfg_len_i;
        r_seed <= cfg_seed_i;
        r_idx  <= '0;
        r_pass <= 1'b0;
      end else if (w_rsp_ok) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      if (r_state == S_DONE) r_pass <= w_pass_now;
    end
  end

`ifdef TGEN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;
  logic            w_in_rsp;

  assign w_in_rsp = (r_state == S_WR_RSP) || (r_state == S_RD_RSP);
  assign w_wd_hit = w_in_rsp && !data_r_valid_i && (r_wd_cnt == WD_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_start_ok)    r_timeout <= 1'b0;
      else if (w_wd_hit) r_timeout <= 1'b1;
      r_wd_cnt <= (w_in_rsp && !data_r_valid_i && !w_wd_hit) ? r_wd_cnt + 1'b1 : '0;
    end
  end

  assign w_timeout = r_timeout;
  assign timeout_o = r_timeout;
`else
  assign w_wd_hit  = (TIMEOUT_CYCLES < 0);
  assign w_timeout = 1'b0;
`endif

  tgen_resp_checker #(
    .ADDR_W(ADDR_IN_WIDTH),
    .DATA_W(DATA_WIDTH),
    .CNT_W (LEN_WIDTH)
  ) u_checker (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clr           (w_start_ok),
    .i_valid         ((r_state == S_RD_RSP) && data_r_valid_i),
    .i_addr          (w_addr),
    .i_exp           (w_pattern),
    .i_act           (data_r_rdata_i),
    .o_err_cnt       (err_cnt_o),
    .o_first_err_addr(first_err_addr_o)
  );

  // During the done cycle the result is shown live so it is valid alongside done_o.
  assign w_pass_now   = (err_cnt_o == '0) && !w_timeout;
  assign pass_o       = (r_state == S_DONE) ? w_pass_now : r_pass;
  assign data_req_o   = w_req;
  assign data_add_o   = w_req ? w_addr : '0;
  assign data_wen_o   = (r_state == S_WR_REQ);
  assign data_wdata_o = (r_state == S_WR_REQ) ? w_pattern : '0;
  assign data_be_o    = {BE_WIDTH{r_state == S_WR_REQ}};
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_tgen_initiator.sv
// Directed bench for tgen_initiator with a randomized-latency slave and a transaction scoreboard.
module tb_tgen_initiator;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LW = 12;
  localparam int EW = 1 + AW + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] cfg_base;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] cfg_seed;
  logic          req, wen, gnt, rvalid;
  logic [AW-1:0] add;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    be;
  logic          busy, done, pass;
  logic [LW-1:0] err_cnt;
  logic [AW-1:0] first_err;
  logic [2:0]    dbg_state;
`ifdef TGEN_TIMEOUT_EN
  logic          timeout;
`endif

  tgen_initiator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .cfg_base_i      (cfg_base),
    .cfg_len_i       (cfg_len),
    .cfg_seed_i      (cfg_seed),
    .data_req_o      (req),
    .data_add_o      (add),
    .data_wen_o      (wen),
    .data_wdata_o    (wdata),
    .data_be_o       (be),
    .data_gnt_i      (gnt),
    .data_r_valid_i  (rvalid),
    .data_r_rdata_i  (rdata),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .err_cnt_o       (err_cnt),
    .first_err_addr_o(first_err),
`ifdef TGEN_TIMEOUT_EN
    .timeout_o       (timeout),
`endif
    .dbg_state_o     (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            slv_no_resp = 1'b0;
  bit            slv_corrupt = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  function automatic logic [DW-1:0] model_pat(input logic [DW-1:0] seed, input logic [AW-1:0] a);
    return seed ^ {6'd0, a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Slave: random grant wait 0..2, response latency 0..2 cycles after the grant edge.
  initial begin : slave
    int gw;
    int lat;
    bit pend;
    bit holding;
    logic [DW-1:0] pdata;
    logic [EW-1:0] held;
    logic [EW-1:0] e;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    gw = 0; lat = 0; pend = 1'b0; holding = 1'b0; pdata = '0; held = '0;
    forever begin
      @(posedge clk); #1;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      if (!rst_n) begin
        pend = 1'b0; holding = 1'b0;
      end else if (pend) begin
        if (!slv_no_resp) begin
          if (lat == 0) begin rvalid = 1'b1; rdata = pdata; pend = 1'b0; end
          else lat--;
        end
      end else if (req) begin
        if (holding) chk("req_hold", {wen, add, wdata}, held);
        else begin
          holding = 1'b1; held = {wen, add, wdata}; gw = $urandom_range(0, 2);
        end
        if (gw == 0) begin
          gnt = 1'b1; holding = 1'b0;
          if (exp_q.size() == 0) chk("unexpected_req", {wen, add}, 64'hdead);
          else begin
            e = exp_q.pop_front();
            chk("req_txn", {wen, add, wdata}, e);
          end
          chk("req_be", be, wen ? 4'hf : 4'h0);
          if (wen) mem[add] = wdata;
          else pdata = mem[add] ^ ((slv_corrupt && add == corrupt_addr) ? 32'h0000_0100 : 32'h0);
          pend = 1'b1; lat = $urandom_range(0, 2);
        end else gw--;
      end
    end
  end

  task automatic run(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic [DW-1:0] seed,
                     input bit ex_pass, input logic [LW-1:0] ex_err, input logic [AW-1:0] ex_first,
                     input bit inject_start);
    int n;
    int budget;
    logic [AW-1:0] a;
    for (int k = 0; k < int'(len); k++) begin
      a = base + AW'(k);
      exp_q.push_back({1'b1, a, model_pat(seed, a)});
    end
    for (int k = 0; k < int'(len); k++) begin
      a = base + AW'(k);
      exp_q.push_back({1'b0, a, 32'h0});
    end
    budget = 16 * int'(len) + 20;
    @(posedge clk); #1;
    start = 1'b1; cfg_base = base; cfg_len = len; cfg_seed = seed;
    @(posedge clk); #1;
    start = 1'b0; cfg_base = AW'($urandom); cfg_len = LW'($urandom); cfg_seed = $urandom;
    chk("busy_t1", busy, 1'b1);
    chk("req_t1", req, len != '0);
    n = 0;
    while (!done && n < budget) begin
      if (inject_start && n == 5) begin
        start = 1'b1; cfg_base = 13'h0aaa; cfg_len = 12'd3;
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
    if (len == '0) chk("zero_len_done_latency", n, 0);
    chk("done_busy", busy, 1'b1);
    chk("done_pass", pass, ex_pass);
    chk("done_err_cnt", err_cnt, ex_err);
    chk("done_first_err", first_err, ex_first);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("pass_hold", pass, ex_pass);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : stim
    int n;
    logic [AW-1:0] b;
    logic [LW-1:0] l;
    start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_seed = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    run(13'h00fe, 12'd1, 32'hdea0bee0, 1'b1, 12'd0, 13'h0, 1'b0);
    run(13'h1ffe, 12'd4, 32'h1234_5678, 1'b1, 12'd0, 13'h0, 1'b0);
    run(13'h0000, 12'd16, $urandom, 1'b1, 12'd0, 13'h0, 1'b1);
    run(13'h1000, 12'd16, $urandom, 1'b1, 12'd0, 13'h0, 1'b0);

    slv_corrupt = 1'b1; corrupt_addr = 13'h0012;
    run(13'h0010, 12'd8, 32'hcafe_f00d, 1'b0, 12'd1, 13'h0012, 1'b0);
    slv_corrupt = 1'b0;

    run(13'h0555, 12'd0, 32'h0, 1'b1, 12'd0, 13'h0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      b = AW'($urandom);
      l = LW'($urandom_range(1, 12));
      run(b, l, $urandom, 1'b1, 12'd0, 13'h0, 1'b0);
    end

    // Abort a run after a mismatch has been counted.
    slv_corrupt = 1'b1; corrupt_addr = 13'h0040;
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, 13'h0040 + 13'(k), model_pat(32'h5a5a_a5a5, 13'h0040 + 13'(k))});
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, 13'h0040 + 13'(k), 32'h0});
    @(posedge clk); #1;
    start = 1'b1; cfg_base = 13'h0040; cfg_len = 12'd8; cfg_seed = 32'h5a5a_a5a5;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (err_cnt == '0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("pre_abort_err_seen", err_cnt, 12'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_req", req, 1'b0);
    chk("abort_add", add, 0);
    chk("abort_wen_be", {wen, be}, 0);
    chk("abort_wdata", wdata, 0);
    chk("abort_busy_done", {busy, done}, 0);
    chk("abort_pass", pass, 1'b0);
    chk("abort_err_cnt", err_cnt, 0);
    chk("abort_first_err", first_err, 0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    slv_corrupt = 1'b0;
    rst_n = 1'b1;
    run(13'h0200, 12'd3, 32'h0f0f_0f0f, 1'b1, 12'd0, 13'h0, 1'b0);

`ifdef TGEN_TIMEOUT_EN
    slv_no_resp = 1'b1;
    exp_q.push_back({1'b1, 13'h0300, model_pat(32'h1, 13'h0300)});
    @(posedge clk); #1;
    start = 1'b1; cfg_base = 13'h0300; cfg_len = 12'd2; cfg_seed = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 400) begin @(posedge clk); #1; n++; end
    chk("wd_done_seen", done, 1'b1);
    chk("wd_latency_min", n >= 256, 1'b1);
    chk("wd_latency_max", n <= 262, 1'b1);
    chk("wd_timeout", timeout, 1'b1);
    chk("wd_pass", pass, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wd_timeout_rst", timeout, 1'b0);
    slv_no_resp = 1'b0;
    exp_q.delete();
    rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, miscompares so far %0d", n_err);
    $fatal(1, "bench time limit reached");
  end

endmodule
